// File: rtl/display_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | display_pkg : shared constants, scan state type and digit-search helpers   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package display_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] DIG_OFF = 4'hF;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Next set mask bit after idx, wrapping 3->0; idx itself is the last
    // candidate, and an empty mask leaves idx unchanged.
    function automatic logic [1:0] next_set_idx(input logic [3:0] mask,
                                                input logic [1:0] idx);
        logic [1:0] r;
        logic [1:0] j;
        r = idx;
        for (int k = 4; k >= 1; k--) begin
            j = idx + 2'(k);
            if (mask[j]) begin
                r = j;
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] lowest_set_idx(input logic [3:0] mask);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/slot_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | slot_timer : per-slot cycle counter with blank-end and slot-end strobes    |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module slot_timer #(
    parameter int TICK_DIV  = 50000,
    parameter int BLANK_CYC = 8
)(
    input  logic Clk,
    input  logic Rst,
    input  logic i_clr,
    output logic o_blank_done,
    output logic o_slot_done,
    output logic o_show_first
);

    localparam int            CW          = $clog2(TICK_DIV);
    localparam logic [CW-1:0] c_LAST      = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] c_BLANK_END = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] c_SHOW_1ST  = CW'(BLANK_CYC);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A pending clear suppresses the strobes so the FSM cannot leave BLANK.
    assign o_blank_done = !i_clr && (r_cnt == c_BLANK_END);
    assign o_slot_done  = !i_clr && (r_cnt == c_LAST);
    assign o_show_first = (r_cnt == c_SHOW_1ST);

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | display_scan_ctrl : 4-digit common-anode 7-seg scan with blanking & blink  |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYC    = 8,
    parameter int BLINK_FRAMES = 64
)(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       En,
    input  logic [3:0] Dig_Mask,
    input  logic [6:0] Seg0,
    input  logic [6:0] Seg1,
    input  logic [6:0] Seg2,
    input  logic [6:0] Seg3,
    input  logic [3:0] Dp_Mask,
    input  logic       Erro,
    output logic [3:0] SEG_D,
    output logic [6:0] SEGs,
    output logic       SEG_P,
    output logic [1:0] Scan_Idx,
    output logic       Frame_Start
);

    localparam int            BW           = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] c_BLINK_LAST = BW'(BLINK_FRAMES - 1);

    scan_state_t r_state;
    scan_state_t w_state_nxt;

    logic [1:0]    r_idx;
    logic [6:0]    r_snap;
    logic          r_dp;
    logic          r_valid;
    logic [BW-1:0] r_bcnt;
    logic          r_phase;

    logic       w_clr;
    logic       w_blank_done;
    logic       w_slot_done;
    logic       w_show_first;
    logic [6:0] w_seg_sel;
    logic [1:0] w_low_idx;
    logic       w_frame;
    logic       w_wrap;
    logic       w_phase_eff;
    logic       w_blink_off;
    logic [3:0] w_seg_d;
    logic [6:0] w_segs;
    logic       w_seg_p;

    // An empty mask parks the scan at the top of BLANK.
    assign w_clr = !En || ((r_state == ST_BLANK) && (Dig_Mask == 4'h0));

    slot_timer #(
        .TICK_DIV  (TICK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_slot_timer (
        .Clk          (Clk),
        .Rst          (Rst),
        .i_clr        (w_clr),
        .o_blank_done (w_blank_done),
        .o_slot_done  (w_slot_done),
        .o_show_first (w_show_first)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!En) begin
            w_state_nxt = ST_BLANK;
        end else begin
            case (r_state)
                ST_BLANK: if (w_blank_done) w_state_nxt = ST_SHOW;
                ST_SHOW:  if (w_slot_done)  w_state_nxt = ST_BLANK;
                default:  w_state_nxt = ST_BLANK;
            endcase
        end
    end

    always_comb begin
        w_seg_sel = Seg0;
        case (r_idx)
            2'd1:    w_seg_sel = Seg1;
            2'd2:    w_seg_sel = Seg2;
            2'd3:    w_seg_sel = Seg3;
            default: w_seg_sel = Seg0;
        endcase
    end

    // The snapshot is taken once per slot so mid-slot source updates never tear.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_idx   <= 2'd0;
            r_snap  <= SEG_OFF;
            r_dp    <= 1'b0;
            r_valid <= 1'b0;
        end else if (!En) begin
            r_idx   <= lowest_set_idx(Dig_Mask);
            r_valid <= 1'b0;
        end else if ((r_state == ST_SHOW) && w_slot_done) begin
            r_idx   <= next_set_idx(Dig_Mask, r_idx);
        end else if ((r_state == ST_BLANK) && w_blank_done) begin
            r_snap  <= w_seg_sel;
            r_dp    <= Dp_Mask[r_idx];
            r_valid <= Dig_Mask[r_idx];
        end
    end

    assign w_low_idx = lowest_set_idx(Dig_Mask);
    assign w_frame   = En && (r_state == ST_SHOW) && w_show_first && r_valid
                       && Dig_Mask[r_idx] && (r_idx == w_low_idx);
    assign w_wrap    = w_frame && (r_bcnt == c_BLINK_LAST);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (!En) begin
            r_bcnt  <= r_bcnt;
            r_phase <= r_phase;
        end else if (!Erro) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (w_wrap) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
        end else if (w_frame) begin
            r_bcnt  <= r_bcnt + 1'b1;
        end
    end

    // Phase flips take effect on the frame's first SHOW cycle, not one later.
    assign w_phase_eff = (Erro && w_wrap) ? ~r_phase : r_phase;
    assign w_blink_off = Erro && !w_phase_eff;

    always_comb begin
        w_seg_d = DIG_OFF;
        w_segs  = SEG_OFF;
        w_seg_p = 1'b1;
        if (En && (r_state == ST_SHOW) && r_valid) begin
            w_seg_d = ~(4'b0001 << r_idx);
            if (!w_blink_off) begin
                w_segs  = r_snap;
                w_seg_p = ~r_dp;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            SEG_D       <= DIG_OFF;
            SEGs        <= SEG_OFF;
            SEG_P       <= 1'b1;
            Scan_Idx    <= 2'd0;
            Frame_Start <= 1'b0;
        end else begin
            SEG_D       <= w_seg_d;
            SEGs        <= w_segs;
            SEG_P       <= w_seg_p;
            Scan_Idx    <= r_idx;
            Frame_Start <= w_frame;
        end
    end

endmodule
`default_nettype wire
